cic_decim_mc: RTL and testbench
===============================

// Module: cic_decim_mc
// PURPOSE
//  Multi-channel CIC decimator for sigma-delta bitstreams, N channels sharing one decimation counter.
//  Decimation ratio is runtime-selectable as a power of two. Output is normalised so full scale is
//  independent of the selected ratio. Post-reset and post-ratio-change warm-up outputs are suppressed.
//  Sits between the SDM front-end and the downstream FIR/packetiser.
// PARAMETERS
//  CHANNELS         2   number of independent input channels
//  I_WIDTH          2   input sample width, signed two's complement (SDM codes +1=2'b01, -1=2'b11)
//  ORDER            1   number of integrator/comb stages (1..6)
//  MAX_DEC_BITS     6   log2 of maximum decimation ratio
//  O_WIDTH          8   output sample width per channel, signed
//  Derived: W = I_WIDTH + ORDER*MAX_DEC_BITS (internal register width); SEL_W = clog2(MAX_DEC_BITS+1)
// PORTS
//  i_clk      in   1                  system clock
//  i_rst      in   1                  asynchronous, active-high reset
//  i_en       in   1                  sample enable; one input sample per cycle when high
//  i_dec_sel  in   SEL_W              k = log2 decimation ratio; valid 1..MAX_DEC_BITS
//  i_data     in   CHANNELS*I_WIDTH   packed input samples, channel 0 in LSBs
//  o_data     out  CHANNELS*O_WIDTH   packed decimated samples, channel 0 in LSBs
//  o_valid    out  1                  1-cycle strobe: o_data updated this cycle
//  o_clk      out  1                  decimated clock, high for second half of each decimation period
// BEHAVIOUR
//  Reset:
//   - all integrators, combs, counter and warm-up count are zeroed; o_data=0, o_valid=0, o_clk=0
//   - k is latched from i_dec_sel
//  Ratio selection:
//   - i_dec_sel is clamped to 1..MAX_DEC_BITS: 0->1, >MAX->MAX
//   - Sampled only at a decimation boundary. If the clamped value differs from the latched k:
//     new k takes effect next cycle; integrators, combs and counter clear; warm-up restarts.
//  Enable:
//   - i_en=0 freezes all state (counter, integrators, combs, o_clk); o_valid=0
//  Integrators:
//   - per channel, ORDER cascaded registered W-bit accumulators; stage 1 adds sign-extended i_data
//   - Two's-complement wrap-around is intentional; no saturation.
//  Counter:
//   - counts 0..2^k-1 on enabled cycles. A boundary is the enabled cycle with counter==2^k-1.
//   - o_clk = counter bit k-1, registered
//  Combs:
//   - at a boundary, the last integrator output feeds ORDER cascaded combs (y = x - x_prev, delay 1)
//   - combs advance only at boundaries; W-bit wrap-around arithmetic
//  Output:
//   - comb result shifted left by ORDER*(MAX_DEC_BITS-k), then o_data = bits [W-1 -: O_WIDTH] (truncate)
//   - registered: o_data/o_valid update the cycle after a boundary
//   - o_data holds its value between strobes
//  Warm-up:
//   - the first ORDER boundaries after reset or ratio change produce no o_valid and leave o_data unchanged
//   - o_valid first fires after boundary ORDER+1
//  Simultaneous events:
//   - i_rst dominates everything
//   - ratio change at a boundary suppresses that boundary's output
//   - reset mid-period discards the partial period
// TESTING
//  1 Defaults, k=6, both ch +1 constant -> first o_valid after 128th enabled sample, then every 64;
//    o_data = {8'h40,8'h40}.
//  2 Defaults, ch0 +1, ch1 -1 constant -> o_data ch0=8'h40, ch1=8'hC0.
//    Alternating +1/-1 each cycle -> 8'h00.
//  3 k=3, +1 constant -> strobe every 8 samples, o_data still 8'h40 (normalisation).
//    i_dec_sel=0 behaves as k=1; i_dec_sel=7 behaves as k=6.
//  4 Switch i_dec_sel 6->3 mid-period -> change applied at next boundary.
//    That boundary and the next ORDER boundaries give no o_valid; then outputs every 8 samples.
//  5 ORDER=3, MAX_DEC_BITS=4, O_WIDTH=14, k=4, +1 constant -> o_data=14'h1000 after 3 suppressed outputs.
//    Toggle i_en randomly -> same values; strobe spacing counts only enabled cycles.
//  6 Assert i_rst mid-period, async, no clock edge -> o_data=0, o_valid=0, o_clk=0 immediately.
//    After release, warm-up repeats as in test 1.

Source files
------------

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator for sigma-delta bitstreams. All channels share one
// decimation counter; the ratio 2^k is runtime-selectable and the output is normalised.

module cic_decim_lane #(
    parameter int I_WIDTH = 2,
    parameter int ORDER   = 1,
    parameter int W       = 8,
    parameter int O_WIDTH = 8,
    parameter int SH_W    = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic               i_take,
    input  logic               i_emit,
    input  logic [SH_W-1:0]    i_shift,
    input  logic [I_WIDTH-1:0] i_data,
    output logic [O_WIDTH-1:0] o_data
);
    logic [ORDER-1:0][W-1:0] integ_q, integ_d, dly_q, dly_d;
    logic [ORDER:0][W-1:0]   comb;
    logic [W-1:0]            scaled;
    logic [O_WIDTH-1:0]      data_q, data_d;

    always_comb begin
        integ_d = integ_q;
        dly_d   = dly_q;
        data_d  = data_q;
        comb    = '0;
        comb[0] = integ_q[ORDER-1];
        for (int s = 0; s < ORDER; s++) comb[s+1] = comb[s] - dly_q[s];
        // Left shift restores full scale for ratios below the maximum.
        scaled = comb[ORDER] << i_shift;
        if (i_clr) begin
            integ_d = '0;
            dly_d   = '0;
        end else if (i_en) begin
            integ_d[0] = integ_q[0] + {{(W-I_WIDTH){i_data[I_WIDTH-1]}}, i_data};
            for (int s = 1; s < ORDER; s++) integ_d[s] = integ_q[s] + integ_q[s-1];
            if (i_take) begin
                for (int s = 0; s < ORDER; s++) dly_d[s] = comb[s];
            end
        end
        if (i_emit) data_d = scaled[W-1 -: O_WIDTH];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            integ_q <= '0;
            dly_q   <= '0;
            data_q  <= '0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
        end
    end

    assign o_data = data_q;
endmodule

module cic_decim_mc #(
    parameter int CHANNELS     = 2,
    parameter int I_WIDTH      = 2,
    parameter int ORDER        = 1,
    parameter int MAX_DEC_BITS = 6,
    parameter int O_WIDTH      = 8,
    localparam int W           = I_WIDTH + ORDER*MAX_DEC_BITS,
    localparam int SEL_W       = $clog2(MAX_DEC_BITS+1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [SEL_W-1:0]             i_dec_sel,
    input  logic [CHANNELS*I_WIDTH-1:0]  i_data,
    output logic [CHANNELS*O_WIDTH-1:0]  o_data,
    output logic                         o_valid,
    output logic                         o_clk
);
    localparam int WARM_W = $clog2(ORDER+2);
    localparam int SH_W   = $clog2(ORDER*MAX_DEC_BITS+1);
    localparam logic [SEL_W-1:0] KMAX = SEL_W'(MAX_DEC_BITS);

    function automatic logic [SEL_W-1:0] clamp_k(input logic [SEL_W-1:0] s);
        logic [SEL_W-1:0] r;
        r = s;
        if (s == '0) r = SEL_W'(1);
        else if (s > KMAX) r = KMAX;
        return r;
    endfunction

    logic [SEL_W-1:0]        k_q, k_d, k_sel;
    logic [MAX_DEC_BITS-1:0] cnt_q, cnt_d, cnt_last, cnt_half;
    logic [WARM_W-1:0]       warm_q, warm_d;
    logic                    valid_q, valid_d, oclk_q, oclk_d;
    logic                    bnd, chg, take, emit;
    logic [SH_W-1:0]         shift;

    always_comb begin
        k_sel    = clamp_k(i_dec_sel);
        cnt_last = ~({MAX_DEC_BITS{1'b1}} << k_q);
        cnt_half = cnt_last ^ (cnt_last >> 1);
        bnd      = i_en && (cnt_q == cnt_last);
        chg      = bnd && (k_sel != k_q);
        take     = bnd && !chg;
        emit     = take && (warm_q == WARM_W'(ORDER));
        shift    = SH_W'(ORDER * (MAX_DEC_BITS - int'(k_q)));

        k_d     = k_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        oclk_d  = oclk_q;
        valid_d = 1'b0;
        // A ratio change restarts the whole filter; that boundary's output is dropped.
        if (chg) begin
            k_d    = k_sel;
            cnt_d  = '0;
            warm_d = '0;
            oclk_d = 1'b0;
        end else if (i_en) begin
            cnt_d   = bnd ? '0 : cnt_q + MAX_DEC_BITS'(1);
            if (take && !emit) warm_d = warm_q + WARM_W'(1);
            valid_d = emit;
            oclk_d  = |(cnt_d & cnt_half);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            k_q     <= clamp_k(i_dec_sel);
            cnt_q   <= '0;
            warm_q  <= '0;
            valid_q <= 1'b0;
            oclk_q  <= 1'b0;
        end else begin
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
            valid_q <= valid_d;
            oclk_q  <= oclk_d;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        cic_decim_lane #(
            .I_WIDTH (I_WIDTH),
            .ORDER   (ORDER),
            .W       (W),
            .O_WIDTH (O_WIDTH),
            .SH_W    (SH_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (i_en),
            .i_clr   (chg),
            .i_take  (take),
            .i_emit  (emit),
            .i_shift (shift),
            .i_data  (i_data[ch*I_WIDTH +: I_WIDTH]),
            .o_data  (o_data[ch*O_WIDTH +: O_WIDTH])
        );
    end

    assign o_valid = valid_q;
    assign o_clk   = oclk_q;
endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: a default instance and an ORDER=3/MAX_DEC_BITS=4/O_WIDTH=14
// instance share stimulus and are checked every cycle against a closed-form CIC model.

module tb_cic_decim_mc;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [2:0]  sel;
    logic [3:0]  din;
    logic [15:0] oa;
    logic        va, ca;
    logic [27:0] ob;
    logic        vb, cb;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    cic_decim_mc u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dec_sel(sel), .i_data(din),
        .o_data(oa), .o_valid(va), .o_clk(ca)
    );

    cic_decim_mc #(.ORDER(3), .MAX_DEC_BITS(4), .O_WIDTH(14)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_dec_sel(sel), .i_data(din),
        .o_data(ob), .o_valid(vb), .o_clk(cb)
    );

    // Model state, index 0 = default instance, 1 = order-3 instance
    int          mk [2];
    int          mn [2];
    int          mt [2];
    int          mb [2];
    logic [3:0]  hist [2][8192];
    longint      ys [2][2][1024];
    logic        exp_v [2];
    logic [27:0] exp_d [2];
    logic        exp_c [2];

    function automatic int ordr(int d); return d ? 3 : 1;  endfunction
    function automatic int maxb(int d); return d ? 4 : 6;  endfunction
    function automatic int oww(int d);  return d ? 14 : 8; endfunction
    function automatic int www(int d);  return 2 + ordr(d) * maxb(d); endfunction

    function automatic int clampk(int d, int s);
        if (s < 1) return 1;
        if (s > maxb(d)) return maxb(d);
        return s;
    endfunction

    function automatic longint binom(longint n, int r);
        longint c = 1;
        if (r < 0 || n < r) return 0;
        for (int i = 0; i < r; i++) c = c * (n - i) / (i + 1);
        return c;
    endfunction

    // Last-integrator value: each earlier sample weighted by C(age, ORDER-1)
    function automatic longint integ_out(int d, int ch);
        longint s = 0;
        logic [1:0] x;
        int v;
        for (int u = 0; u < mt[d]; u++) begin
            x = hist[d][u][ch*2 +: 2];
            v = $signed(x);
            s += longint'(v) * binom(longint'(mt[d] - 1 - u), ordr(d) - 1);
        end
        return s;
    endfunction

    task automatic model_reset(int d);
        mk[d] = clampk(d, int'(sel));
        mn[d] = 0; mt[d] = 0; mb[d] = 0;
        exp_v[d] = 1'b0; exp_d[d] = '0; exp_c[d] = 1'b0;
    endtask

    task automatic model_step(int d);
        longint c;
        logic [63:0] v, nd;
        int ck;
        exp_v[d] = 1'b0;
        if (!en) return;
        if (mn[d] == (1 << mk[d]) - 1) begin
            ck = clampk(d, int'(sel));
            if (ck != mk[d]) begin
                mk[d] = ck; mn[d] = 0; mt[d] = 0; mb[d] = 0; exp_c[d] = 1'b0;
                return;
            end
            mb[d]++;
            nd = '0;
            for (int ch = 0; ch < 2; ch++) begin
                ys[d][ch][mb[d]] = integ_out(d, ch);
                c = 0;
                for (int j = 0; j <= ordr(d); j++)
                    if (mb[d] - j >= 1)
                        c += ((j % 2) ? -64'sd1 : 64'sd1) * binom(longint'(ordr(d)), j) * ys[d][ch][mb[d]-j];
                v = 64'(c);
                v = v << (ordr(d) * (maxb(d) - mk[d]));
                v = (v >> (www(d) - oww(d))) & ((64'd1 << oww(d)) - 64'd1);
                nd |= v << (ch * oww(d));
            end
            if (mb[d] > ordr(d)) begin
                exp_v[d] = 1'b1;
                exp_d[d] = nd[27:0];
            end
            mn[d] = 0;
        end else begin
            mn[d]++;
        end
        hist[d][mt[d]] = din;
        mt[d]++;
        exp_c[d] = ((mn[d] >> (mk[d] - 1)) & 1) != 0;
    endtask

    task automatic chk(string nm, logic [27:0] act, logic [27:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_valid", 28'(va), 28'(exp_v[0]));
            chk("a_data",  28'(oa), exp_d[0]);
            chk("a_oclk",  28'(ca), 28'(exp_c[0]));
            chk("b_valid", 28'(vb), 28'(exp_v[1]));
            chk("b_data",  ob,      exp_d[1]);
            chk("b_oclk",  28'(cb), 28'(exp_c[1]));
        end
    end

    task automatic tick(bit e, logic [3:0] dv);
        en  = e;
        din = dv;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) model_reset(d);
            else     model_step(d);
        end
    endtask

    task automatic first_valid(string nm);
        int n = 0;
        while (n < 400 && va !== 1'b1) begin
            tick(1'b1, 4'b0101);
            n++;
        end
        chk(nm, 28'(n), 28'd128);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sel = 3'd6; din = 4'b0101;
        model_reset(0); model_reset(1);
        chk_on = 1'b1;
        repeat (3) tick(1'b0, 4'b0101);
        rst = 1'b0;

        // Constant +1 on both channels, k=6 (order-3 instance clamps to 4)
        first_valid("t1_first_valid");
        repeat (128) tick(1'b1, 4'b0101);
        chk("t1_a_lit", 28'(oa), 28'h0004040);
        chk("t1_b_lit", ob, 28'h4001000);

        // ch0 +1, ch1 -1, then alternating polarity
        repeat (200) tick(1'b1, 4'b1101);
        chk("t2_a_lit", 28'(oa), 28'h000C040);
        chk("t2_b_lit", ob, 28'hC001000);
        for (int i = 0; i < 200; i++) tick(1'b1, (i % 2) ? 4'b1111 : 4'b0101);
        chk("t2_a_alt", 28'(oa), 28'h0);
        chk("t2_b_alt", ob, 28'h0);

        // Ratio changes mid-period, including out-of-range selects
        sel = 3'd3;
        repeat (200) tick(1'b1, 4'b0101);
        chk("t3_a_k3", 28'(oa), 28'h0004040);
        chk("t3_b_k3", ob, 28'h4001000);
        sel = 3'd0;
        repeat (100) tick(1'b1, 4'b0101);
        chk("t3_a_k0", 28'(oa), 28'h0004040);
        chk("t3_b_k0", ob, 28'h4001000);
        sel = 3'd7;
        repeat (300) tick(1'b1, 4'b0101);
        chk("t3_a_k7", 28'(oa), 28'h0004040);
        chk("t3_b_k7", ob, 28'h4001000);

        // Random enable gaps
        repeat (600) tick(1'($urandom_range(0, 1)), 4'b0101);
        chk("t5_a_gap", 28'(oa), 28'h0004040);
        chk("t5_b_gap", ob, 28'h4001000);

        // Asynchronous reset between clock edges
        sel = 3'd6;
        repeat (10) tick(1'b1, 4'b0101);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_a_data_async",  28'(oa), 28'h0);
        chk("t6_a_valid_async", 28'(va), 28'h0);
        chk("t6_a_oclk_async",  28'(ca), 28'h0);
        chk("t6_b_data_async",  ob, 28'h0);
        model_reset(0); model_reset(1);
        repeat (2) tick(1'b1, 4'b0101);
        rst = 1'b0;
        first_valid("t6_first_valid");
        repeat (70) tick(1'b1, 4'b0101);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
